cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
Parametrised successor to the CPU fetch/execute control unit. It sequences FETCH -> EXECUTE -> (FETCH | TRAP) and generalises the fixed div/rem and load/store wait cases to NUM_UNITS multi-cycle functional units. It also generalises the two interrupt inputs to a NUM_IRQ-wide prioritised, maskable vector, and adds a bus/unit watchdog timeout. It sits between the decoder/functional units and the PC/fetch logic inside the CPU.

Parameters:
NUM_UNITS, 4, number of multi-cycle units the executing instruction may wait on (bit 0 conventionally tied to the bus data-valid for load/store).
NUM_IRQ, 2, number of interrupt request lines; the higher index has higher priority.
TIMEOUT_CYCLES, 1024, maximum cycles spent waiting in FETCH or EXECUTE before an error trap; 0 disables the watchdog.

Ports:
i_clk  in  1  clock, all logic on rising edge.
i_rst_n  in  1  synchronous active-low reset.
i_bus_DV  in  1  fetch data valid from bus.
i_wait_sel  in  NUM_UNITS  per-instruction mask of units whose completion EXECUTE must wait for; all zero means a single-cycle instruction.
i_unit_done  in  NUM_UNITS  per-unit completion, level, sampled in EXECUTE.
i_irq  in  NUM_IRQ  interrupt requests, level.
i_irq_en  in  NUM_IRQ  interrupt enable mask.
i_trap_finished  in  1  trap handler sequence complete; exits TRAP and ERROR.
o_state  out  2  0=FETCH, 1=EXECUTE, 2=TRAP, 3=ERROR.
o_load_PC  out  1  combinational; PC update strobe.
o_start_fetch  out  1  registered one-cycle pulse requesting the next fetch.
o_irq_take  out  1  registered one-cycle pulse on entry to TRAP.
o_irq_id  out  max(1,$clog2(NUM_IRQ))  index of the taken interrupt; held until the next take.
o_timeout_err  out  1  registered one-cycle pulse on entry to ERROR.

Behaviour:
- Reset (i_rst_n low at a clock edge): state FETCH, watchdog count 0, all outputs 0, o_irq_id 0. Reset takes effect from any state, including mid-wait.
- Boot: in the first cycle after i_rst_n rises, o_start_fetch pulses once.
- done = &(i_unit_done | ~i_wait_sel). Multi-hot i_wait_sel waits for all selected units; all-zero i_wait_sel gives done=1.
- pending = i_irq & i_irq_en. The winner is the highest set index.
- o_load_PC = (state==EXECUTE) & done, combinational, with no further qualification.
- FETCH: i_bus_DV -> EXECUTE on the next cycle. Interrupts are not sampled in FETCH.
- EXECUTE with done:
  - if |pending: go to TRAP, pulse o_irq_take, and latch o_irq_id = winner.
  - else: go to FETCH and pulse o_start_fetch.
- EXECUTE without done: remain in EXECUTE.
- Interrupts are sampled only in the cycle where done is true. A request that drops before that cycle is not taken.
- TRAP: i_trap_finished -> FETCH and pulse o_start_fetch. i_irq is ignored in TRAP, so there is no nesting.
- ERROR: entered from FETCH or EXECUTE when the watchdog expires.
  - o_timeout_err pulses on entry.
  - i_trap_finished -> FETCH and pulse o_start_fetch.
- Watchdog:
  - Counts cycles spent in FETCH without i_bus_DV and in EXECUTE without done.
  - Clears on every state transition.
  - When the count reaches TIMEOUT_CYCLES-1 and the completion condition is still false, the next state is ERROR. Entry to ERROR occurs on the clock edge ending the TIMEOUT_CYCLES-th waiting cycle.
  - Completion arriving in the same cycle as expiry wins; no error is raised.
  - The counter saturates and does not wrap. TIMEOUT_CYCLES=0 disables the watchdog entirely.
- o_start_fetch, o_irq_take and o_timeout_err are each high for exactly one cycle per event. At most one of them is high in any cycle.

Test Plan:
- Reset then single-cycle instruction:
  - Stimulus: i_rst_n low 2 cycles then high; i_bus_DV at cycle 3; i_wait_sel=0.
  - Required response: boot o_start_fetch pulse in cycle 1; o_state 0->1; o_load_PC=1 for one cycle in EXECUTE; then FETCH with o_start_fetch pulse.
- Multi-unit wait:
  - Stimulus: i_wait_sel=4'b0101; unit 0 done at +2, unit 2 done at +5.
  - Required response: o_load_PC stays 0 until +5, is 1 at +5 only, and the state returns to 0.
- Interrupt priority and mask:
  - Stimulus: NUM_IRQ=4; i_irq=4'b1010, i_irq_en=4'b0111, asserted at completion of EXECUTE.
  - Required response: TRAP with o_irq_id=1 and o_irq_take pulse; i_trap_finished -> FETCH plus o_start_fetch.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8; EXECUTE with i_wait_sel=1, unit never done.
  - Required response: ERROR after 8 cycles with o_timeout_err pulse. Repeat with done in the 8th waiting cycle: no error, normal completion.
- Reset mid-wait:
  - Stimulus: assert i_rst_n low while in EXECUTE waiting on a unit, with the watchdog at 5.
  - Required response: next cycle state 0, counter 0, no pulses; boot o_start_fetch after release.
- Masked/late interrupt:
  - Stimulus: i_irq high only during the FETCH phase, or with i_irq_en=0.
  - Required response: no TRAP; normal FETCH return.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Fetch/execute control sequencer: waits on multi-cycle units, takes prioritised
// maskable interrupts into TRAP, and falls into ERROR when a wait runs too long.
module cpu_sequencer #(
  parameter int NUM_UNITS      = 4,
  parameter int NUM_IRQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_bus_DV,
  input  logic [NUM_UNITS-1:0] i_wait_sel,
  input  logic [NUM_UNITS-1:0] i_unit_done,
  input  logic [NUM_IRQ-1:0]   i_irq,
  input  logic [NUM_IRQ-1:0]   i_irq_en,
  input  logic                 i_trap_finished,
  output logic [1:0]           o_state,
  output logic                 o_load_PC,
  output logic                 o_start_fetch,
  output logic                 o_irq_take,
  output logic [ID_W-1:0]      o_irq_id,
  output logic                 o_timeout_err
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    TRAP    = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              WD_ON    = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   wd_count;
  logic               boot_pending;
  logic               done;
  logic               waiting;
  logic [NUM_IRQ-1:0] pending;
  logic [ID_W-1:0]    winner;
  logic               start_next, take_next, err_next;

  assign done      = &(i_unit_done | ~i_wait_sel);
  assign pending   = i_irq & i_irq_en;
  assign o_load_PC = (state == EXECUTE) && done;
  assign o_state   = state;

  // Ascending scan so the highest pending index is the one left standing.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    next_state = state;
    start_next = 1'b0;
    take_next  = 1'b0;
    err_next   = 1'b0;
    waiting    = 1'b0;
    case (state)
      FETCH: begin
        if (i_bus_DV) next_state = EXECUTE;
        else          waiting    = 1'b1;
      end
      EXECUTE: begin
        if (done) begin
          if (|pending) begin
            next_state = TRAP;
            take_next  = 1'b1;
          end else begin
            next_state = FETCH;
            start_next = 1'b1;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      TRAP, ERROR: begin
        if (i_trap_finished) begin
          next_state = FETCH;
          start_next = 1'b1;
        end
      end
      default: next_state = FETCH;
    endcase
    // Expiry only applies while still waiting, so a same-cycle completion wins.
    if (WD_ON && waiting && (wd_count == CNT_LAST)) begin
      next_state = ERROR;
      err_next   = 1'b1;
    end
    if (boot_pending && (next_state != ERROR)) start_next = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= FETCH;
      wd_count      <= '0;
      boot_pending  <= 1'b1;
      o_start_fetch <= 1'b0;
      o_irq_take    <= 1'b0;
      o_timeout_err <= 1'b0;
      o_irq_id      <= '0;
    end else begin
      state         <= next_state;
      boot_pending  <= 1'b0;
      o_start_fetch <= start_next;
      o_irq_take    <= take_next;
      o_timeout_err <= err_next;
      if (take_next) o_irq_id <= winner;
      if (next_state != state)              wd_count <= '0;
      else if (waiting && (wd_count != '1)) wd_count <= wd_count + 1'b1;
    end
  end

endmodule
